lcd_result_display: RTL and testbench
=====================================

Name: lcd_result_display

Overview:
- Downstream display stage of the convolution core. It consumes one stored convolution result at a time, as produced during the controller's display states (crw=11, cond selecting the result slot).
- Converts each signed 16-bit result to decimal ASCII.
- Drives an HD44780-compatible character LCD over its 8-bit parallel bus.
- Owns LCD power-up initialisation and all bus timing.

Parameters:
- PWRUP_CYC, 1000000: clk cycles to wait after reset before the first LCD command (20 ms at 50 MHz).
- E_HIGH_CYC, 25: lcd_e high time per bus write, in cycles.
- CMD_WAIT_CYC, 2500: post-write wait for normal commands and data (50 us).
- CLR_WAIT_CYC, 100000: post-write wait after the clear command 0x01 (2 ms).

Ports:
- clk, input, 1: system clock; one clock domain.
- reset, input, 1: asynchronous, active-low reset.
- res_valid, input, 1: result present; accepted on a clk edge where res_valid=1 and ready=1.
- res_idx, input, 5: result slot, same encoding as cond. 0-3 serial C11/C12/C21/C22; 4-7 3x3; 8-11 2x2.
- res_data, input, 16: result value, two's complement.
- ready, output, 1: block idle and able to accept.
- lcd_e, output, 1: LCD enable strobe.
- lcd_rs, output, 1: 0 = command, 1 = data.
- lcd_rw, output, 1: held at 0 (write only).
- lcd_data, output, 8: LCD data bus.

Behaviour:
- Reset (reset=0, asynchronous):
  - ready=0, lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=8'h00.
  - FSM goes to PWR_WAIT; counters cleared; any latched result discarded.
  - Reset asserted mid-operation aborts immediately and the full init sequence reruns after release.
- FSM states: PWR_WAIT, INIT, IDLE, CONVERT, WRITE.
- PWR_WAIT: counts PWRUP_CYC cycles, then moves to INIT.
- INIT: issues commands 0x38, 0x0C, 0x06, 0x01 in that order, then moves to IDLE.
- Byte write primitive, applied to every command and character:
  - 1 setup cycle: lcd_e=0, lcd_rs and lcd_data valid.
  - E_HIGH_CYC cycles with lcd_e=1.
  - Wait cycles with lcd_e=0: CLR_WAIT_CYC for 0x01, CMD_WAIT_CYC otherwise.
  - lcd_rs and lcd_data are held stable for the whole primitive.
  - lcd_data returns to 0 only on reset.
- IDLE:
  - ready=1.
  - On res_valid=1, latch res_idx and res_data; ready=0 from the next cycle; go to CONVERT.
  - res_valid while ready=0 is ignored, not queued.
- CONVERT:
  - Magnitude = |res_data| computed as 17-bit, so -32768 gives 32768; sign flag = res_data[15].
  - Double-dabble into 5 BCD digits, one bit per cycle, exactly 16 cycles. Then go to WRITE.
- WRITE: 15 byte writes in this order.
  - cmd 0x80.
  - 7 characters, line 1: mode string, space, 'C', row digit, column digit.
    - Mode string: idx 0-3 "SER"; 4-7 "3X3"; 8-11 "2X2"; 12-31 "---".
    - Row = '1' + idx[1]; column = '1' + idx[0].
  - cmd 0xC0.
  - 6 characters, line 2: sign ('+' for >=0, '-' for <0), then 5 digits with leading zeros (ASCII 0x30+d).
  - After the last write, go to IDLE.
- Latency: ready returns to 1 exactly 16 + 15*(1+E_HIGH_CYC+CMD_WAIT_CYC) cycles after the accept edge.
- No clear command is issued during updates; each update fully overwrites the 13 used cells.
- Zero is displayed as "+00000"; sign is never '-' for zero.

Test Plan:
Bench parameters: PWRUP_CYC=10, E_HIGH_CYC=2, CMD_WAIT_CYC=4, CLR_WAIT_CYC=8; byte slot is 7 cycles (11 for clear).
1. Release reset; hold res_valid=0 → lcd_e stays 0 for 10 cycles. Then bytes 0x38, 0x0C, 0x06, 0x01 appear with rs=0, each E pulse exactly 2 cycles wide. ready rises 32 cycles after PWR_WAIT ends.
2. idx=5, data=16'd1234 → LCD bytes 0x80, "3X3 C12", 0xC0, "+01234". rs=0 only for 0x80 and 0xC0. ready=1 again 121 cycles after accept.
3. idx=2, data=16'h8000 → "SER C21" and "-32768". idx=11, data=16'hFFFF → "2X2 C22" and "-00001".
4. idx=0, data=0 → "+00000". idx=20 → line 1 "--- C11" (idx[1:0]=00).
5. Pulse res_valid with a new value during WRITE → ignored; the display sequence in progress completes unchanged and no second sequence follows.
6. Assert reset mid-WRITE (for example during the 4th character) → all outputs 0 asynchronously. After release, the full PWR_WAIT+INIT sequence repeats before ready=1.

Source files
------------

// File: rtl/lcd_result_display.sv
// Displays one signed 16-bit convolution result on an HD44780 character LCD.
// Handles power-up init, binary-to-decimal conversion and all 8-bit bus timing.
module lcd_result_display #(
  parameter int unsigned PWRUP_CYC    = 1000000,
  parameter int unsigned E_HIGH_CYC   = 25,
  parameter int unsigned CMD_WAIT_CYC = 2500,
  parameter int unsigned CLR_WAIT_CYC = 100000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        res_valid_i,
  input  logic [4:0]  res_idx_i,
  input  logic [15:0] res_data_i,
  output logic        ready_o,
  output logic        lcd_e_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic [7:0]  lcd_data_o
);

  localparam int unsigned MaxWait = (CLR_WAIT_CYC > CMD_WAIT_CYC) ? CLR_WAIT_CYC : CMD_WAIT_CYC;
  localparam int unsigned CycW    = $clog2(E_HIGH_CYC + MaxWait + 1);
  localparam int unsigned PwrW    = $clog2(PWRUP_CYC + 1);

  typedef enum logic [2:0] {StPwrWait, StInit, StIdle, StConvert, StWrite} state_e;

  state_e            state_q;
  logic [PwrW-1:0]   pwr_cnt_q;
  logic [CycW-1:0]   cyc_q;
  logic [3:0]        byte_q;
  logic [3:0]        conv_cnt_q;
  logic [4:0]        idx_q;
  logic              neg_q;
  logic [15:0]       mag_q;
  logic [19:0]       bcd_q;
  logic              ready_q;
  logic              lcd_e_q;
  logic              lcd_rs_q;
  logic [7:0]        lcd_data_q;

  logic [15:0]       bcd_adj;
  logic [19:0]       bcd_shift;
  logic [15:0]       mag_abs;
  logic [CycW-1:0]   last_cyc;
  logic              byte_done;
  logic [3:0]        nxt_byte;
  logic [3:0]        last_byte;

  function automatic logic [8:0] init_byte(input logic [3:0] i);
    logic [8:0] b;
    case (i)
      4'd0:    b = 9'h038;
      4'd1:    b = 9'h00C;
      4'd2:    b = 9'h006;
      default: b = 9'h001;
    endcase
    return b;
  endfunction

  // Returns {rs, data} for write-sequence position i: 0x80, 7 chars, 0xC0, 6 chars.
  function automatic logic [8:0] write_byte(input logic [3:0] i, input logic [4:0] idx,
                                            input logic neg, input logic [19:0] bcd);
    logic [23:0] mode;
    logic [8:0]  b;
    if (idx < 5'd4)       mode = "SER";
    else if (idx < 5'd8)  mode = "3X3";
    else if (idx < 5'd12) mode = "2X2";
    else                  mode = "---";
    case (i)
      4'd0:    b = 9'h080;
      4'd1:    b = {1'b1, mode[23:16]};
      4'd2:    b = {1'b1, mode[15:8]};
      4'd3:    b = {1'b1, mode[7:0]};
      4'd4:    b = {1'b1, 8'h20};
      4'd5:    b = {1'b1, 8'h43};
      4'd6:    b = {1'b1, 8'h31 + {7'd0, idx[1]}};
      4'd7:    b = {1'b1, 8'h31 + {7'd0, idx[0]}};
      4'd8:    b = 9'h0C0;
      4'd9:    b = {1'b1, neg ? 8'h2D : 8'h2B};
      4'd10:   b = {1'b1, 8'h30 + {4'd0, bcd[19:16]}};
      4'd11:   b = {1'b1, 8'h30 + {4'd0, bcd[15:12]}};
      4'd12:   b = {1'b1, 8'h30 + {4'd0, bcd[11:8]}};
      4'd13:   b = {1'b1, 8'h30 + {4'd0, bcd[7:4]}};
      default: b = {1'b1, 8'h30 + {4'd0, bcd[3:0]}};
    endcase
    return b;
  endfunction

  // Top digit never exceeds 1 before the last shift (max 32768), so it needs no adjust.
  always_comb begin
    bcd_adj = bcd_q[15:0];
    for (int k = 0; k < 4; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  assign bcd_shift = {bcd_q[18:16], bcd_adj, mag_q[15]};
  // |-32768| = 32768 still fits 16 unsigned bits.
  assign mag_abs   = res_data_i[15] ? (~res_data_i + 16'd1) : res_data_i;

  always_comb begin
    last_cyc = CycW'(E_HIGH_CYC + CMD_WAIT_CYC);
    if (!lcd_rs_q && lcd_data_q == 8'h01) last_cyc = CycW'(E_HIGH_CYC + CLR_WAIT_CYC);
  end

  assign byte_done = (cyc_q == last_cyc);
  assign nxt_byte  = byte_q + 4'd1;
  assign last_byte = (state_q == StInit) ? 4'd3 : 4'd14;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StPwrWait;
      pwr_cnt_q  <= '0;
      cyc_q      <= '0;
      byte_q     <= '0;
      conv_cnt_q <= '0;
      idx_q      <= '0;
      neg_q      <= 1'b0;
      mag_q      <= '0;
      bcd_q      <= '0;
      ready_q    <= 1'b0;
      lcd_e_q    <= 1'b0;
      lcd_rs_q   <= 1'b0;
      lcd_data_q <= 8'h00;
    end else begin
      case (state_q)
        StPwrWait: begin
          if (pwr_cnt_q == PwrW'(PWRUP_CYC - 1)) begin
            state_q                <= StInit;
            byte_q                 <= '0;
            cyc_q                  <= '0;
            {lcd_rs_q, lcd_data_q} <= init_byte(4'd0);
          end else begin
            pwr_cnt_q <= pwr_cnt_q + PwrW'(1);
          end
        end
        StInit, StWrite: begin
          if (byte_done) begin
            lcd_e_q <= 1'b0;
            if (byte_q == last_byte) begin
              state_q <= StIdle;
              ready_q <= 1'b1;
            end else begin
              byte_q <= nxt_byte;
              cyc_q  <= '0;
              if (state_q == StInit) {lcd_rs_q, lcd_data_q} <= init_byte(nxt_byte);
              else {lcd_rs_q, lcd_data_q} <= write_byte(nxt_byte, idx_q, neg_q, bcd_q);
            end
          end else begin
            cyc_q   <= cyc_q + CycW'(1);
            lcd_e_q <= (cyc_q < CycW'(E_HIGH_CYC));
          end
        end
        StIdle: begin
          if (res_valid_i) begin
            state_q    <= StConvert;
            idx_q      <= res_idx_i;
            neg_q      <= res_data_i[15];
            mag_q      <= mag_abs;
            bcd_q      <= '0;
            conv_cnt_q <= '0;
            ready_q    <= 1'b0;
          end
        end
        StConvert: begin
          bcd_q      <= bcd_shift;
          mag_q      <= {mag_q[14:0], 1'b0};
          conv_cnt_q <= conv_cnt_q + 4'd1;
          if (conv_cnt_q == 4'd15) begin
            state_q                <= StWrite;
            byte_q                 <= '0;
            cyc_q                  <= '0;
            {lcd_rs_q, lcd_data_q} <= 9'h080;
          end
        end
        default: state_q <= StPwrWait;
      endcase
    end
  end

  assign ready_o    = ready_q;
  assign lcd_e_o    = lcd_e_q;
  assign lcd_rs_o   = lcd_rs_q;
  assign lcd_rw_o   = 1'b0;
  assign lcd_data_o = lcd_data_q;

endmodule

// File: tb/tb_lcd_result_display.sv
// Bench for lcd_result_display: per-cycle timeline model of the LCD bus plus literal
// expectations on captured byte streams and latencies.
module tb_lcd_result_display;

  localparam int unsigned PWR = 10;
  localparam int unsigned EH  = 2;
  localparam int unsigned CW  = 4;
  localparam int unsigned CL  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        res_valid = 1'b0;
  logic [4:0]  res_idx = '0;
  logic [15:0] res_data = '0;
  logic        ready, lcd_e, lcd_rs, lcd_rw;
  logic [7:0]  lcd_data;

  typedef struct packed {
    logic       rdy;
    logic       e;
    logic       rs;
    logic [7:0] data;
  } exp_t;

  exp_t       mq[$];
  logic [8:0] cap[$];
  int         n_checks = 0;
  int         n_pass = 0;
  logic       mdl_up = 1'b0;
  logic       mdl_rs = 1'b0;
  logic [7:0] mdl_data = '0;
  logic       prev_rst = 1'b0;

  lcd_result_display #(
    .PWRUP_CYC(PWR), .E_HIGH_CYC(EH), .CMD_WAIT_CYC(CW), .CLR_WAIT_CYC(CL)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .res_valid_i(res_valid), .res_idx_i(res_idx),
    .res_data_i(res_data), .ready_o(ready), .lcd_e_o(lcd_e), .lcd_rs_o(lcd_rs),
    .lcd_rw_o(lcd_rw), .lcd_data_o(lcd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // One byte slot on the bus: setup, E high, then the post-write wait.
  function automatic void push_byte(input logic rs, input logic [7:0] d);
    int unsigned w;
    exp_t x;
    w = (!rs && d == 8'h01) ? CL : CW;
    x.rdy = 1'b0; x.rs = rs; x.data = d;
    x.e = 1'b0; mq.push_back(x);
    x.e = 1'b1; for (int i = 0; i < int'(EH); i++) mq.push_back(x);
    x.e = 1'b0; for (int i = 0; i < int'(w); i++) mq.push_back(x);
  endfunction

  function automatic void push_init();
    exp_t z;
    z = '0;
    for (int i = 0; i < int'(PWR) - 1; i++) mq.push_back(z);
    push_byte(1'b0, 8'h38);
    push_byte(1'b0, 8'h0C);
    push_byte(1'b0, 8'h06);
    push_byte(1'b0, 8'h01);
  endfunction

  function automatic void push_display(input logic [4:0] idx, input logic [15:0] d);
    int    v, mag, dv;
    string mode;
    exp_t  x;
    v = int'(signed'(d));
    mag = (v < 0) ? -v : v;
    if (idx < 4) mode = "SER";
    else if (idx < 8) mode = "3X3";
    else if (idx < 12) mode = "2X2";
    else mode = "---";
    x.rdy = 1'b0; x.e = 1'b0; x.rs = mdl_rs; x.data = mdl_data;
    for (int i = 0; i < 16; i++) mq.push_back(x);
    push_byte(1'b0, 8'h80);
    for (int i = 0; i < 3; i++) push_byte(1'b1, mode[i]);
    push_byte(1'b1, 8'h20);
    push_byte(1'b1, 8'h43);
    push_byte(1'b1, 8'(49 + int'(idx[1])));
    push_byte(1'b1, 8'(49 + int'(idx[0])));
    push_byte(1'b0, 8'hC0);
    push_byte(1'b1, (v < 0) ? 8'h2D : 8'h2B);
    dv = 10000;
    for (int i = 0; i < 5; i++) begin
      push_byte(1'b1, 8'(48 + (mag / dv) % 10));
      dv = dv / 10;
    end
  endfunction

  // Per-cycle compare of every output against the model timeline.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mq.delete();
        mdl_up = 1'b0; mdl_rs = 1'b0; mdl_data = '0;
        x = '0;
      end else if (mq.size() > 0) begin
        x = mq.pop_front();
        mdl_rs = x.rs; mdl_data = x.data;
      end else begin
        x.rdy = mdl_up; x.e = 1'b0; x.rs = mdl_rs; x.data = mdl_data;
      end
      n_checks++;
      if (ready === x.rdy && lcd_e === x.e && lcd_rs === x.rs && lcd_rw === 1'b0 &&
          lcd_data === x.data) begin
        n_pass++;
      end else begin
        $display("FAIL cycle @%0t: got rdy=%b e=%b rs=%b rw=%b data=%h, expected rdy=%b e=%b rs=%b rw=0 data=%h",
                 $time, ready, lcd_e, lcd_rs, lcd_rw, lcd_data, x.rdy, x.e, x.rs, x.data);
      end
      if (rst_n && !prev_rst) begin
        push_init();
        mdl_up = 1'b1;
      end else if (rst_n && x.rdy && res_valid) begin
        push_display(res_idx, res_data);
      end
      prev_rst = rst_n;
    end
  end

  initial begin
    forever begin
      @(posedge lcd_e);
      cap.push_back({lcd_rs, lcd_data});
    end
  end

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic start_tx(input logic [4:0] idx, input logic [15:0] d);
    cap.delete();
    res_idx = idx; res_data = d; res_valid = 1'b1;
    @(posedge clk); #1;
    res_valid = 1'b0;
  endtask

  task automatic send(input logic [4:0] idx, input logic [15:0] d, output int lat);
    start_tx(idx, d);
    wait_ready(lat);
  endtask

  task automatic chk_disp(input string l1, input string l2);
    chk("disp_len", cap.size(), 15);
    if (cap.size() == 15) begin
      chk("disp_cmd_line1", int'(cap[0]), 'h080);
      for (int i = 0; i < 7; i++) chk({"disp_line1 ", l1}, int'(cap[i+1]), 256 + int'(l1[i]));
      chk("disp_cmd_line2", int'(cap[8]), 'h0C0);
      for (int i = 0; i < 6; i++) chk({"disp_line2 ", l2}, int'(cap[i+9]), 256 + int'(l2[i]));
    end
  endtask

  task automatic chk_init();
    chk("init_len", cap.size(), 4);
    if (cap.size() == 4) begin
      chk("init_b0", int'(cap[0]), 'h038);
      chk("init_b1", int'(cap[1]), 'h00C);
      chk("init_b2", int'(cap[2]), 'h006);
      chk("init_b3", int'(cap[3]), 'h001);
    end
  endtask

  initial begin
    int n;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", int'({ready, lcd_e, lcd_rs, lcd_rw, lcd_data}), 0);
    cap.delete();
    rst_n = 1'b1;
    wait_ready(n);
    chk("init_latency", n, 42);
    chk_init();

    send(5'd5, 16'd1234, n);
    chk("latency_3x3", n, 121);
    chk_disp("3X3 C12", "+01234");

    send(5'd2, 16'h8000, n);
    chk("latency_min", n, 121);
    chk_disp("SER C21", "-32768");

    send(5'd11, 16'hFFFF, n);
    chk_disp("2X2 C22", "-00001");

    send(5'd0, 16'd0, n);
    chk_disp("SER C11", "+00000");

    send(5'd20, 16'd7, n);
    chk_disp("--- C11", "+00007");

    // New request mid-write must be dropped, not queued.
    start_tx(5'd6, 16'd999);
    repeat (40) @(posedge clk);
    #1;
    res_idx = 5'd9; res_data = 16'd5555; res_valid = 1'b1;
    @(posedge clk); #1;
    res_valid = 1'b0;
    wait_ready(n);
    chk("latency_ignored", n, 80);
    chk_disp("3X3 C21", "+00999");
    repeat (30) @(posedge clk);
    #1;
    chk("no_second_seq", cap.size(), 15);
    chk("ready_after_ignore", int'(ready), 1);

    // Abort mid-write with an asynchronous reset.
    start_tx(5'd1, 16'd42);
    repeat (45) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset", int'({ready, lcd_e, lcd_rs, lcd_rw, lcd_data}), 0);
    repeat (3) @(posedge clk);
    #1;
    cap.delete();
    rst_n = 1'b1;
    wait_ready(n);
    chk("reinit_latency", n, 42);
    chk_init();

    send(5'd4, 16'd32767, n);
    chk_disp("3X3 C11", "+32767");

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
